// File: rtl/spi_regs_ctrl.sv
// SPI register file and transfer sequencer (start/arm/active with start timeout).
// Optional interrupt enable register and irq_o when SPI_REGS_IRQ_EN is defined.
module spi_regs_ctrl #(
  parameter int SS_NUM    = 4,
  parameter int CLKDIV_W  = 8,
  parameter int BYTECNT_W = 8,
  parameter int START_TO  = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 spi_busy_i,
  input  logic                 spi_done_i,
  input  logic                 rx_empty_i,
  input  logic                 tx_full_i,
  input  logic [31:0]          reg_data_i,
  input  logic                 reg_load_i,
  input  logic [2:0]           reg_sel_i,
  output logic [31:0]          reg_rdata_o,
  output logic [CLKDIV_W-1:0]  clk_div_o,
  output logic                 data_order_o,
  output logic                 cpol_o,
  output logic                 cpha_o,
  output logic                 qspi_o,
  output logic [SS_NUM-1:0]    ss_en_o,
  output logic                 r_w_n_o,
  output logic [BYTECNT_W-1:0] byte_num_o,
  output logic                 trans_start_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int CNT_W = (START_TO > 2) ? $clog2(START_TO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(START_TO - 1);
  localparam int RW_B  = SS_NUM;
  localparam int BN_B  = SS_NUM + 1;
  localparam int ST_B  = SS_NUM + BYTECNT_W + 1;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 start_q;
  logic [CLKDIV_W-1:0]  clk_div_q;
  logic                 dord_q;
  logic                 cpol_q;
  logic                 cpha_q;
  logic                 qspi_q;
  logic [SS_NUM-1:0]    ss_en_q;
  logic                 rnw_q;
  logic [BYTECNT_W-1:0] byte_q;
  logic                 busy_q;
  logic                 rxe_q;
  logic                 txf_q;
  logic [2:0]           flags_q;
  logic [2:0]           flags_d;

  logic locked;
  logic wr_ctrl;
  logic wr_tc;
  logic wr_err;
  logic set_done;
  logic set_to;
  logic [2:0] clr;
  logic unused_data;

  assign unused_data = ^reg_data_i;

  assign locked  = (state_q != IDLE);
  assign wr_ctrl = reg_load_i && (reg_sel_i == 3'd0) && !locked;
  assign wr_tc   = reg_load_i && (reg_sel_i == 3'd1) && !locked;
  assign wr_err  = reg_load_i && locked &&
                   ((reg_sel_i == 3'd0) || (reg_sel_i == 3'd1));

  assign set_done = (state_q == ACTIVE) && spi_done_i;
  assign set_to   = (state_q == ARMED) && !busy_q && (cnt_q == CNT_MAX);

  assign clr = (reg_load_i && reg_sel_i == 3'd3) ? reg_data_i[2:0] : 3'b000;

  // A flag raised in the same cycle as its clear survives.
  assign flags_d = (flags_q & ~clr) | {set_to, wr_err, set_done};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wr_tc && reg_data_i[ST_B]) begin
            state_q <= ARMED;
            cnt_q   <= '0;
            start_q <= 1'b1;
          end
        end
        ARMED: begin
          if (busy_q) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (spi_done_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      clk_div_q <= '0;
      dord_q    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      qspi_q    <= 1'b0;
      ss_en_q   <= SS_NUM'(1);
      rnw_q     <= 1'b0;
      byte_q    <= '0;
      busy_q    <= 1'b0;
      rxe_q     <= 1'b0;
      txf_q     <= 1'b0;
      flags_q   <= 3'b000;
    end else begin
      busy_q  <= spi_busy_i;
      rxe_q   <= rx_empty_i;
      txf_q   <= tx_full_i;
      flags_q <= flags_d;
      if (wr_ctrl) begin
        clk_div_q <= reg_data_i[CLKDIV_W-1:0];
        dord_q    <= reg_data_i[CLKDIV_W];
        cpol_q    <= reg_data_i[CLKDIV_W+1];
        cpha_q    <= reg_data_i[CLKDIV_W+2];
        qspi_q    <= reg_data_i[CLKDIV_W+3];
      end
      if (wr_tc) begin
        ss_en_q <= reg_data_i[SS_NUM-1:0];
        rnw_q   <= reg_data_i[RW_B];
        byte_q  <= reg_data_i[BN_B +: BYTECNT_W];
      end
    end
  end

`ifdef SPI_REGS_IRQ_EN
  logic [2:0] irq_en_q;
  logic       irq_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      irq_en_q <= 3'b000;
      irq_q    <= 1'b0;
    end else begin
      if (reg_load_i && reg_sel_i == 3'd4) irq_en_q <= reg_data_i[2:0];
      irq_q <= |(flags_q & irq_en_q);
    end
  end

  assign irq_o = irq_q;
`else
  logic [2:0] irq_en_q;
  assign irq_en_q = 3'b000;
  assign irq_o    = 1'b0;
`endif

  always_comb begin
    reg_rdata_o = '0;
    case (reg_sel_i)
      3'd0: begin
        reg_rdata_o[CLKDIV_W-1:0]  = clk_div_q;
        reg_rdata_o[CLKDIV_W +: 4] = {qspi_q, cpha_q, cpol_q, dord_q};
      end
      3'd1: begin
        reg_rdata_o[SS_NUM-1:0]         = ss_en_q;
        reg_rdata_o[RW_B]               = rnw_q;
        reg_rdata_o[BN_B +: BYTECNT_W]  = byte_q;
        reg_rdata_o[ST_B]               = locked;
      end
      3'd2: reg_rdata_o[4:0] = {state_q, txf_q, rxe_q, busy_q};
      3'd3: reg_rdata_o[2:0] = flags_q;
      3'd4: reg_rdata_o[2:0] = irq_en_q;
      3'd5: reg_rdata_o = {16'h0002, 8'(SS_NUM), 8'(BYTECNT_W)};
      default: reg_rdata_o = '0;
    endcase
  end

  assign clk_div_o     = clk_div_q;
  assign data_order_o  = dord_q;
  assign cpol_o        = cpol_q;
  assign cpha_o        = cpha_q;
  assign qspi_o        = qspi_q;
  assign ss_en_o       = ss_en_q;
  assign r_w_n_o       = rnw_q;
  assign byte_num_o    = byte_q;
  assign trans_start_o = start_q;

endmodule

// File: tb/tb_spi_regs_ctrl.sv
// Scoreboard bench for spi_regs_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_spi_regs_ctrl;

  localparam int SS_NUM    = 4;
  localparam int CLKDIV_W  = 8;
  localparam int BYTECNT_W = 8;
  localparam int START_TO  = 16;
`ifdef SPI_REGS_IRQ_EN
  localparam logic [31:0] IRQ = 32'd1;
`else
  localparam logic [31:0] IRQ = 32'd0;
`endif

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic                 spi_busy_i;
  logic                 spi_done_i;
  logic                 rx_empty_i;
  logic                 tx_full_i;
  logic [31:0]          reg_data_i;
  logic                 reg_load_i;
  logic [2:0]           reg_sel_i;
  logic [31:0]          reg_rdata_o;
  logic [CLKDIV_W-1:0]  clk_div_o;
  logic                 data_order_o;
  logic                 cpol_o;
  logic                 cpha_o;
  logic                 qspi_o;
  logic [SS_NUM-1:0]    ss_en_o;
  logic                 r_w_n_o;
  logic [BYTECNT_W-1:0] byte_num_o;
  logic                 trans_start_o;
  logic                 irq_o;

  spi_regs_ctrl #(
    .SS_NUM(SS_NUM), .CLKDIV_W(CLKDIV_W),
    .BYTECNT_W(BYTECNT_W), .START_TO(START_TO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .spi_busy_i(spi_busy_i), .spi_done_i(spi_done_i),
    .rx_empty_i(rx_empty_i), .tx_full_i(tx_full_i),
    .reg_data_i(reg_data_i), .reg_load_i(reg_load_i),
    .reg_sel_i(reg_sel_i), .reg_rdata_o(reg_rdata_o),
    .clk_div_o(clk_div_o), .data_order_o(data_order_o),
    .cpol_o(cpol_o), .cpha_o(cpha_o), .qspi_o(qspi_o),
    .ss_en_o(ss_en_o), .r_w_n_o(r_w_n_o),
    .byte_num_o(byte_num_o), .trans_start_o(trans_start_o),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {
    K_RD, K_CLKDIV, K_SS, K_BYTE, K_START, K_IRQ, K_MODE, K_SCNT
  } kind_e;

  typedef struct {
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   scnt = 0;

  function automatic logic [31:0] observe(kind_e k);
    case (k)
      K_RD:     return reg_rdata_o;
      K_CLKDIV: return 32'(clk_div_o);
      K_SS:     return 32'(ss_en_o);
      K_BYTE:   return 32'(byte_num_o);
      K_START:  return 32'(trans_start_o);
      K_IRQ:    return 32'(irq_o);
      K_MODE:   return 32'({qspi_o, cpha_o, cpol_o,
                            data_order_o, r_w_n_o});
      K_SCNT:   return 32'(scnt);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk_i) begin
    exp_t e;
    logic [31:0] act;
    if (trans_start_o === 1'b1) scnt++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = observe(e.kind);
      n_chk++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic want(kind_e k, logic [31:0] v, string n);
    sbq.push_back('{kind: k, val: v, name: n});
  endtask

  task automatic rd(logic [2:0] s, logic [31:0] v, string n);
    reg_sel_i = s;
    want(K_RD, v, n);
    tick();
  endtask

  task automatic wr(logic [2:0] s, logic [31:0] d);
    reg_sel_i  = s;
    reg_data_i = d;
    reg_load_i = 1'b1;
    tick();
    reg_load_i = 1'b0;
    reg_data_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i    = 1'b1;
    spi_busy_i = 1'b0;
    spi_done_i = 1'b0;
    rx_empty_i = 1'b0;
    tx_full_i  = 1'b0;
    reg_data_i = '0;
    reg_load_i = 1'b0;
    reg_sel_i  = '0;
    tick();
    tick();

    want(K_CLKDIV, 0, "rst_clkdiv");
    want(K_SS, 1, "rst_ss");
    want(K_BYTE, 0, "rst_byte");
    want(K_START, 0, "rst_start");
    want(K_IRQ, 0, "rst_irq");
    want(K_MODE, 0, "rst_mode");
    rd(0, 32'h0, "rst_sel0");
    rd(1, 32'h1, "rst_sel1");
    rd(2, 32'h0, "rst_sel2");
    rd(3, 32'h0, "rst_sel3");
    rd(4, 32'h0, "rst_sel4");
    rd(5, 32'h0002_0408, "rst_sel5");
    rd(6, 32'h0, "rst_sel6");
    rd(7, 32'h0, "rst_sel7");
    reset_i = 1'b0;
    tick();
    rd(1, 32'h1, "post_rst_sel1");

    rx_empty_i = 1'b1;
    tx_full_i  = 1'b1;
    rd(2, 32'h0, "status_lag");
    rd(2, 32'h6, "status_reg");
    rx_empty_i = 1'b0;
    tx_full_i  = 1'b0;
    tick();
    wr(4, 32'h1);
    rd(4, IRQ, "irq_en_rb");
    wr(6, 32'hFFFF);
    rd(6, 32'h0, "sel6_ignored");
    rd(2, 32'h0, "status_idle");

    // transfer: ss=2, byte_num=3, write, start
    wr(1, 32'h2062);
    want(K_START, 1, "start_pulse");
    want(K_BYTE, 3, "byte_num");
    want(K_SS, 2, "ss_en");
    rd(1, 32'h2062, "tc_rb_armed");
    want(K_START, 0, "start_one_cycle");
    rd(2, 32'h08, "st_armed");
    spi_busy_i = 1'b1;
    rd(2, 32'h08, "st_busy_lag");
    rd(2, 32'h09, "st_armed_busyq");
    rd(2, 32'h11, "st_active");
    for (int i = 0; i < 5; i++) tick();
    wr(0, 32'hFF);
    want(K_CLKDIV, 0, "lock_clkdiv");
    rd(3, 32'h2, "wr_err_set");
    wr(3, 32'h2);
    rd(3, 32'h0, "wr_err_clr");
    wr(1, 32'h5);
    want(K_SS, 2, "lock_ss");
    rd(3, 32'h2, "wr_err_tc");
    reg_sel_i  = 3'd3;
    reg_data_i = 32'h3;
    reg_load_i = 1'b1;
    spi_done_i = 1'b1;
    tick();
    reg_load_i = 1'b0;
    spi_done_i = 1'b0;
    want(K_IRQ, 0, "irq_lat0");
    rd(2, 32'h01, "st_idle_after_done");
    want(K_IRQ, IRQ, "irq_rise");
    rd(3, 32'h1, "done_set_wins");
    rd(1, 32'h62, "tc_rb_idle");
    spi_busy_i = 1'b0;
    wr(3, 32'h1);
    want(K_IRQ, IRQ, "irq_hold");
    rd(3, 32'h0, "done_clr");
    want(K_IRQ, 0, "irq_fall");
    tick();

    // start timeout with busy held low
    wr(1, 32'h2001);
    want(K_START, 1, "to_start");
    rd(2, 32'h08, "to_armed0");
    for (int i = 0; i < 14; i++) rd(2, 32'h08, "to_armed");
    rd(2, 32'h08, "to_armed_last");
    rd(2, 32'h00, "to_idle");
    want(K_START, 0, "to_no_restart");
    rd(3, 32'h4, "to_flag");
    want(K_SCNT, 2, "to_start_count");
    rd(1, 32'h1, "to_tc_rb");
    wr(3, 32'h4);
    rd(3, 32'h0, "to_clr");

    wr(0, 32'hFA5);
    want(K_CLKDIV, 32'hA5, "ctrl_clkdiv");
    want(K_MODE, 32'h1E, "ctrl_mode");
    rd(0, 32'hFA5, "ctrl_rb");

    // reset asserted while armed
    wr(1, 32'h2054);
    want(K_START, 1, "arm_start");
    want(K_MODE, 32'h1F, "arm_mode");
    want(K_SS, 4, "arm_ss");
    want(K_BYTE, 2, "arm_byte");
    @(negedge clk_i);
    #1;
    reset_i = 1'b1;
    want(K_START, 0, "rst_start_async");
    want(K_CLKDIV, 0, "rst2_clkdiv");
    want(K_SS, 1, "rst2_ss");
    want(K_BYTE, 0, "rst2_byte");
    want(K_MODE, 0, "rst2_mode");
    want(K_IRQ, 0, "rst2_irq");
    tick();
    rd(2, 32'h0, "rst2_state");
    rd(1, 32'h1, "rst2_sel1");
    reset_i = 1'b0;
    tick();
    tick();
    tick();
    want(K_SCNT, 3, "no_start_after_rst");
    want(K_START, 0, "rst2_start_low");
    rd(2, 32'h0, "post_rst2_idle");
    tick();

    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
